// File: rtl/select_starvation_ctrl_pkg.sv
// Shared types and helpers for the select-tree starvation controller.
package select_starvation_ctrl_pkg;

  localparam int SSC_ISSUE_DEPTH = 128;
  localparam int SSC_SIZE_SELECT_BLOCK = 16;
  localparam int NUM_GROUPS = SSC_ISSUE_DEPTH / SSC_SIZE_SELECT_BLOCK;
  localparam int GROUP_LOG = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  typedef enum logic [0:0] {
    SSC_NORMAL = 1'b0,
    SSC_BOOST  = 1'b1
  } ssc_state_t;

  function automatic int unsigned group_of(input int unsigned entry, input int unsigned blk);
    return entry / blk;
  endfunction

endpackage

// File: rtl/select_starvation_ctrl_pick.sv
// ssc_circ_pick: combinational circular priority picker. First set bit of reqVec
// found scanning upward from ptr, wrapping at N.
module ssc_circ_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] reqVec,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && reqVec[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        idx   = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/select_starvation_ctrl.sv
// Starvation guard in front of the issue-queue select tree: per-group denial counters
// and a boost FSM that restricts requests to one starved group. Optional stats: SELECT_STARVE_STATS_EN.
module select_starvation_ctrl
  import select_starvation_ctrl_pkg::*;
#(
  parameter int ISSUE_DEPTH       = SSC_ISSUE_DEPTH,
  parameter int SIZE_SELECT_BLOCK = SSC_SIZE_SELECT_BLOCK,
  parameter int STARVE_LIMIT      = 8,
  parameter int BOOST_CYCLES      = 4,
  localparam int NG = ISSUE_DEPTH / SIZE_SELECT_BLOCK,
  localparam int GW = (NG > 1) ? $clog2(NG) : 1,
  localparam int EW = $clog2(ISSUE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ISSUE_DEPTH-1:0] requestVector_i,
  input  logic                   stall_i,
  input  logic                   grantedValid_i,
  input  logic [EW-1:0]          grantedEntry_i,
  output logic [ISSUE_DEPTH-1:0] maskedRequest_o,
  output logic                   boostActive_o,
  output logic [GW-1:0]          boostGroup_o
`ifdef SELECT_STARVE_STATS_EN
  ,
  output logic [31:0]            boostCount_o,
  output logic [31:0]            starveCycles_o
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (BOOST_CYCLES > 1) ? $clog2(BOOST_CYCLES) : 1;
  localparam logic [0:0] ST_NORMAL = SSC_NORMAL;
  localparam logic [0:0] ST_BOOST  = SSC_BOOST;

  logic [0:0]           state;
  logic [GW-1:0]        rrPtr, boostGroup, pickIdx, nextPtr;
  logic [TW-1:0]        boostTimer;
  logic [NG-1:0][CW-1:0] starveCnt;
  logic [NG-1:0]        anyReq, grantHit, starved, grpPass;
  logic                 pickValid, boostExit, maskBypass;

  // A boost on a group with nothing to issue is bypassed so no select slot goes idle.
  assign maskBypass = (state != ST_BOOST) || !anyReq[boostGroup];

  for (genvar g = 0; g < NG; g++) begin : g_grp
    assign anyReq[g]   = |requestVector_i[g*SIZE_SELECT_BLOCK +: SIZE_SELECT_BLOCK];
    assign grantHit[g] = grantedValid_i &&
                         (group_of(32'(grantedEntry_i), SIZE_SELECT_BLOCK) == g);
    assign starved[g]  = (starveCnt[g] == CW'(STARVE_LIMIT));
    assign grpPass[g]  = maskBypass || (boostGroup == GW'(g));
    assign maskedRequest_o[g*SIZE_SELECT_BLOCK +: SIZE_SELECT_BLOCK] =
      grpPass[g] ? requestVector_i[g*SIZE_SELECT_BLOCK +: SIZE_SELECT_BLOCK] : '0;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                           starveCnt[g] <= '0;
      else if (!stall_i) begin
        if (!anyReq[g] || grantHit[g])     starveCnt[g] <= '0;
        else if (!starved[g])              starveCnt[g] <= starveCnt[g] + 1'b1;
      end
    end
  end

  ssc_circ_pick #(.N(NG), .W(GW)) u_pick (
    .reqVec (starved),
    .ptr    (rrPtr),
    .valid  (pickValid),
    .idx    (pickIdx)
  );

  assign nextPtr   = (boostGroup == GW'(NG - 1)) ? '0 : boostGroup + 1'b1;
  assign boostExit = grantHit[boostGroup] || (boostTimer == '0) || !anyReq[boostGroup];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_NORMAL;
      rrPtr      <= '0;
      boostGroup <= '0;
      boostTimer <= '0;
    end else if (!stall_i) begin
      case (state)
        ST_NORMAL: if (pickValid) begin
          boostGroup <= pickIdx;
          boostTimer <= TW'(BOOST_CYCLES - 1);
          state      <= ST_BOOST;
        end
        default: if (boostExit) begin
          state <= ST_NORMAL;
          rrPtr <= nextPtr;
        end else begin
          boostTimer <= boostTimer - 1'b1;
        end
      endcase
    end
  end

  assign boostActive_o = (state == ST_BOOST);
  assign boostGroup_o  = boostGroup;

`ifdef SELECT_STARVE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boostCount_o   <= '0;
      starveCycles_o <= '0;
    end else if (!stall_i) begin
      if (state == ST_NORMAL && pickValid) boostCount_o   <= boostCount_o + 1'b1;
      if (|starved)                        starveCycles_o <= starveCycles_o + 1'b1;
    end
  end
`endif

endmodule
